cntdn_timer: RTL and testbench



---
 rtl/cntdn_timer.sv | 118 +++++++++++
 tb/tb_cntdn_timer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cntdn_timer.sv
// MM:SS BCD countdown timer with an internal one-second prescaler and IDLE/RUN/PAUSE/DONE control.
// Latency: control inputs act at the next edge; the first decrement lands tick_div_p edges after start.
// Backpressure: none. Inputs are level requests sampled every cycle, and load_i overrides start_i and pause_i.
module cntdn_timer #(
    parameter int tick_div_p = 50000000
) (
    input  logic        clk_i,
    input  logic        nRst_i,
    input  logic        load_i,
    input  logic [15:0] preset_i,
    input  logic        start_i,
    input  logic        pause_i,
    output logic [15:0] digits_o,
    output logic        running_o,
    output logic        done_o,
    output logic        expired_o
);

    localparam int PW = (tick_div_p > 2) ? $clog2(tick_div_p) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(tick_div_p - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [15:0]   digits;
    logic [PW-1:0] presc;
    logic          expired;

    logic [15:0]   preset_clamped;
    logic [15:0]   digits_dec;
    logic          tick;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction

    always_comb begin
        preset_clamped = {clamp_digit(preset_i[15:12], 4'd5), clamp_digit(preset_i[11:8], 4'd9),
                          clamp_digit(preset_i[7:4],   4'd5), clamp_digit(preset_i[3:0],  4'd9)};
    end

    // Borrow ripples upward: a digit moves only when every digit below it is zero.
    always_comb begin
        digits_dec = digits;
        digits_dec[3:0] = (digits[3:0] == 4'd0) ? 4'd9 : digits[3:0] - 4'd1;
        if (digits[3:0] == 4'd0) begin
            digits_dec[7:4] = (digits[7:4] == 4'd0) ? 4'd5 : digits[7:4] - 4'd1;
            if (digits[7:4] == 4'd0) begin
                digits_dec[11:8] = (digits[11:8] == 4'd0) ? 4'd9 : digits[11:8] - 4'd1;
                if (digits[11:8] == 4'd0 && digits[15:12] != 4'd0) begin
                    digits_dec[15:12] = digits[15:12] - 4'd1;
                end
            end
        end
    end

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            state   <= IDLE;
            digits  <= 16'h0000;
            presc   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load_i) begin
                state  <= IDLE;
                digits <= preset_clamped;
                presc  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && digits != 16'h0000) begin
                            state <= RUN;
                            presc <= '0;
                        end
                    end
                    RUN: begin
                        presc <= tick ? '0 : presc + PW'(1);
                        if (tick) begin
                            digits <= digits_dec;
                            if (digits_dec == 16'h0000) begin
                                state   <= DONE;
                                expired <= 1'b1;
                            end else if (pause_i) begin
                                state <= PAUSE;
                            end
                        end else if (pause_i) begin
                            state <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        // Prescaler is left alone so the partial second survives the pause.
                        if (start_i && !pause_i) begin
                            state <= RUN;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign digits_o  = digits;
    assign running_o = (state == RUN);
    assign done_o    = (state == DONE);
    assign expired_o = expired;

endmodule

// File: tb/tb_cntdn_timer.sv
// Directed bench for cntdn_timer with a 4-cycle tick; all checks sampled on the falling edge.
module tb_cntdn_timer;

    logic        clk_i = 1'b0;
    logic        nRst_i;
    logic        load_i;
    logic [15:0] preset_i;
    logic        start_i;
    logic        pause_i;
    logic [15:0] digits_o;
    logic        running_o;
    logic        done_o;
    logic        expired_o;

    int checks = 0;
    int failures = 0;

    cntdn_timer #(.tick_div_p(4)) dut (
        .clk_i     (clk_i),
        .nRst_i    (nRst_i),
        .load_i    (load_i),
        .preset_i  (preset_i),
        .start_i   (start_i),
        .pause_i   (pause_i),
        .digits_o  (digits_o),
        .running_o (running_o),
        .done_o    (done_o),
        .expired_o (expired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load_i = 1'b1;
        preset_i = v;
        cyc(1);
        load_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    initial begin
        nRst_i = 1'b0;
        load_i = 1'b0;
        preset_i = 16'h0000;
        start_i = 1'b0;
        pause_i = 1'b0;
        cyc(2);
        chk("rst_digits", digits_o, 16'h0000);
        chk("rst_running", {15'd0, running_o}, 16'd0);
        chk("rst_done", {15'd0, done_o}, 16'd0);
        chk("rst_expired", {15'd0, expired_o}, 16'd0);
        nRst_i = 1'b1;
        cyc(1);

        // Simple count with S1 borrow
        do_load(16'h0012);
        chk("load12_digits", digits_o, 16'h0012);
        chk("load12_running", {15'd0, running_o}, 16'd0);
        do_start();
        chk("start_running", {15'd0, running_o}, 16'd1);
        cyc(3);
        chk("pre_tick_hold", digits_o, 16'h0012);
        cyc(1);
        chk("tick1", digits_o, 16'h0011);
        cyc(4);
        chk("tick2", digits_o, 16'h0010);
        cyc(4);
        chk("tick3_borrow", digits_o, 16'h0009);

        // Pause with prescaler at 2, hold, resume
        cyc(1);
        pause_i = 1'b1;
        cyc(1);
        pause_i = 1'b0;
        chk("pause_running", {15'd0, running_o}, 16'd0);
        cyc(10);
        chk("pause_hold", digits_o, 16'h0009);
        do_start();
        chk("resume_running", {15'd0, running_o}, 16'd1);
        cyc(1);
        chk("resume_r1", digits_o, 16'h0009);
        cyc(1);
        chk("resume_r2", digits_o, 16'h0008);

        // start and pause together in RUN
        start_i = 1'b1;
        pause_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
        pause_i = 1'b0;
        chk("start_pause_both", {15'd0, running_o}, 16'd0);

        // Cascaded borrow across three digits
        do_load(16'h1000);
        do_start();
        cyc(4);
        chk("cascade", digits_o, 16'h0959);

        // Pause coinciding with a tick: decrement taken, then PAUSE
        do_load(16'h0003);
        do_start();
        cyc(3);
        pause_i = 1'b1;
        cyc(1);
        pause_i = 1'b0;
        chk("pause_tick_digits", digits_o, 16'h0002);
        chk("pause_tick_running", {15'd0, running_o}, 16'd0);

        // load during RUN
        do_start();
        chk("rerun", {15'd0, running_o}, 16'd1);
        do_load(16'h0002);
        chk("load_in_run_digits", digits_o, 16'h0002);
        chk("load_in_run_running", {15'd0, running_o}, 16'd0);

        // Expiry
        do_start();
        cyc(4);
        chk("exp_tick1", digits_o, 16'h0001);
        chk("exp_tick1_pulse", {15'd0, expired_o}, 16'd0);
        cyc(4);
        chk("exp_digits", digits_o, 16'h0000);
        chk("exp_pulse", {15'd0, expired_o}, 16'd1);
        chk("exp_done", {15'd0, done_o}, 16'd1);
        chk("exp_running", {15'd0, running_o}, 16'd0);
        cyc(1);
        chk("exp_pulse_end", {15'd0, expired_o}, 16'd0);
        chk("done_stays", {15'd0, done_o}, 16'd1);
        do_start();
        cyc(5);
        chk("done_ign_start_run", {15'd0, running_o}, 16'd0);
        chk("done_ign_start_digits", digits_o, 16'h0000);
        chk("done_ign_start_done", {15'd0, done_o}, 16'd1);
        do_load(16'h0005);
        chk("done_load_done", {15'd0, done_o}, 16'd0);
        chk("done_load_digits", digits_o, 16'h0005);

        // Clamping and zero start
        do_load(16'h7A7F);
        chk("clamp", digits_o, 16'h5959);
        do_load(16'h0000);
        do_start();
        chk("zero_start_running", {15'd0, running_o}, 16'd0);
        cyc(5);
        chk("zero_start_digits", digits_o, 16'h0000);
        chk("zero_start_done", {15'd0, done_o}, 16'd0);

        // Asynchronous reset mid-run
        do_load(16'h0030);
        do_start();
        cyc(5);
        chk("prereset_digits", digits_o, 16'h0029);
        #2;
        nRst_i = 1'b0;
        #1;
        chk("async_rst_digits", digits_o, 16'h0000);
        chk("async_rst_running", {15'd0, running_o}, 16'd0);
        chk("async_rst_done", {15'd0, done_o}, 16'd0);
        chk("async_rst_expired", {15'd0, expired_o}, 16'd0);
        cyc(1);
        nRst_i = 1'b1;
        cyc(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
